pwm_breather: RTL and testbench

- Upstream stage that drives the pwm block's step and duty inputs to produce a "breathing" LED waveform.
- A prescaler generates the step strobe.
- A four-phase FSM ramps duty up, holds at full, ramps down, and holds at zero, in ramp ticks derived from step.
- Outputs connect directly to pwm: step to step, duty to duty, ena passed alongside.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/strobe_divider.sv | 51 +++++
 rtl/pwm_breather.sv | 110 +++++++++++
 tb/tb_pwm_breather.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and default widths for the breathing-LED duty generator.
// The phase encoding is visible on the phase output, so its values are fixed.
package pwm_pkg;

  localparam int PRESCALE_W_DEF = 16;
  localparam int RAMP_W_DEF     = 8;

  typedef enum logic [1:0] {
    LOW_HOLD  = 2'd0,
    RISE      = 2'd1,
    HIGH_HOLD = 2'd2,
    FALL      = 2'd3
  } breath_phase_t;

endpackage

// File: rtl/strobe_divider.sv
// Counter that fires once every limit+1 enabled cycles, using a >= compare so a
// shrinking limit takes effect at once. Strobe is either registered or combinational.
module strobe_divider
  import pwm_pkg::*;
#(
  parameter int W       = PRESCALE_W_DEF,
  parameter bit REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [W-1:0] limit,
  output logic         strobe
);

  logic [W-1:0] cnt;
  logic         hit;

  assign hit = (cnt >= limit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (ena) begin
      cnt <= hit ? '0 : cnt + W'(1);
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic strobe_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          strobe_q <= 1'b0;
        end else begin
          strobe_q <= ena & hit;
        end
      end

      assign strobe = strobe_q;
    end else begin : g_comb
      // Acts in the same edge as the enabling pulse, so the caller's state
      // changes exactly at the compare edge.
      assign strobe = ena & hit;
    end
  endgenerate

endmodule

// File: rtl/pwm_breather.sv
// Drives a downstream pwm with a breathing duty: ramp up, hold full, ramp down,
// hold zero. Step comes from a prescaler; ramp ticks are every ramp_steps+1 steps.
module pwm_breather
  import pwm_pkg::*;
#(
  parameter int N          = 8,
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int RAMP_W     = RAMP_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [RAMP_W-1:0]     ramp_steps,
  input  logic [N-1:0]          delta,
  input  logic [RAMP_W-1:0]     hold,
  output logic                  step,
  output logic [N-1:0]          duty,
  output logic [1:0]            phase,
  output logic                  cycle_done
);

  localparam logic [N:0] MAX = {1'b0, {N{1'b1}}};

  breath_phase_t     phase_q;
  logic [RAMP_W-1:0] hcnt;
  logic              ramp_ena;
  logic              tick;
  logic [N:0]        d_eff;
  logic [N:0]        rise_sum;
  logic              hold_done;
  logic              fall_done;

  strobe_divider #(
    .W       (PRESCALE_W),
    .REG_OUT (1'b1)
  ) u_step_div (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .limit  (prescale),
    .strobe (step)
  );

  // The step counter only advances on step pulses while running.
  assign ramp_ena = ena & step;

  strobe_divider #(
    .W       (RAMP_W),
    .REG_OUT (1'b0)
  ) u_tick_div (
    .clk    (clk),
    .rst    (rst),
    .ena    (ramp_ena),
    .limit  (ramp_steps),
    .strobe (tick)
  );

  // One extra bit of headroom keeps duty+d and the fall compare free of wrap.
  always_comb begin
    d_eff     = (delta == '0) ? (N+1)'(1) : {1'b0, delta};
    rise_sum  = {1'b0, duty} + d_eff;
    hold_done = (hcnt == hold);
    fall_done = ({1'b0, duty} <= d_eff);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      duty       <= '0;
      phase_q    <= LOW_HOLD;
      hcnt       <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      if (tick) begin
        case (phase_q)
          LOW_HOLD, HIGH_HOLD: begin
            if (hold_done) begin
              hcnt    <= '0;
              phase_q <= (phase_q == LOW_HOLD) ? RISE : FALL;
            end else begin
              hcnt <= hcnt + RAMP_W'(1);
            end
          end
          RISE: begin
            if (rise_sum >= MAX) begin
              duty    <= MAX[N-1:0];
              phase_q <= HIGH_HOLD;
            end else begin
              duty <= rise_sum[N-1:0];
            end
          end
          FALL: begin
            if (fall_done) begin
              duty       <= '0;
              phase_q    <= LOW_HOLD;
              cycle_done <= 1'b1;
            end else begin
              duty <= duty - d_eff[N-1:0];
            end
          end
          default: phase_q <= LOW_HOLD;
        endcase
      end
    end
  end

  assign phase = phase_q;

endmodule

// File: tb/tb_pwm_breather.sv
// Self-checking bench for pwm_breather at N=4: directed scenarios against fixed
// expectations plus a randomized run against a cycle-level reference model.
module tb_pwm_breather;

  localparam int N_TB = 4;
  localparam int MAXV = (1 << N_TB) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic [15:0] prescale = '0;
  logic [7:0]  ramp_steps = '0;
  logic [3:0]  delta = '0;
  logic [7:0]  hold = '0;
  logic        step;
  logic [3:0]  duty;
  logic [1:0]  phase;
  logic        cycle_done;

  int checks = 0;
  int errors = 0;

  pwm_breather #(
    .N          (N_TB),
    .PRESCALE_W (16),
    .RAMP_W     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .prescale   (prescale),
    .ramp_steps (ramp_steps),
    .delta      (delta),
    .hold       (hold),
    .step       (step),
    .duty       (duty),
    .phase      (phase),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  // Reference model: step period is prescale+1 enabled cycles, a ramp tick is
  // every ramp_steps+1 steps, and the level follows the breathing rules.
  int m_pcnt = 0, m_scnt = 0, m_hcnt = 0, m_level = 0, m_ph = 0;
  bit m_step = 0, m_cd = 0;

  always @(posedge clk) begin
    bit do_tick;
    int d;
    if (!rst) begin
      m_pcnt = 0; m_scnt = 0; m_hcnt = 0; m_level = 0; m_ph = 0;
      m_step = 0; m_cd = 0;
    end else if (!ena) begin
      m_step = 0;
      m_cd   = 0;
    end else begin
      do_tick = m_step && (m_scnt >= int'(ramp_steps));
      if (m_step) m_scnt = do_tick ? 0 : m_scnt + 1;
      m_cd = 0;
      d = (delta == 0) ? 1 : int'(delta);
      if (do_tick) begin
        if (m_ph == 0 || m_ph == 2) begin
          if (m_hcnt == int'(hold)) begin
            m_hcnt = 0;
            m_ph   = m_ph + 1;
          end else begin
            m_hcnt = (m_hcnt + 1) % 256;
          end
        end else if (m_ph == 1) begin
          if (m_level + d >= MAXV) begin
            m_level = MAXV;
            m_ph    = 2;
          end else begin
            m_level = m_level + d;
          end
        end else begin
          if (m_level <= d) begin
            m_level = 0;
            m_ph    = 0;
            m_cd    = 1;
          end else begin
            m_level = m_level - d;
          end
        end
      end
      if (m_pcnt >= int'(prescale)) begin
        m_pcnt = 0;
        m_step = 1;
      end else begin
        m_pcnt = m_pcnt + 1;
        m_step = 0;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ena = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic sweep_config();
    prescale   = 16'd0;
    ramp_steps = 8'd0;
    delta      = 4'd4;
    hold       = 8'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ena = 1'b1;
    prescale = 16'd0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      checks++;
      if (duty !== 4'd0 || step !== 1'b0 || phase !== 2'd0 || cycle_done !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: duty=%0d step=%b phase=%0d cycle_done=%b, want all 0",
                 c, duty, step, phase, cycle_done);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_step_timing();
    do_reset();
    prescale = 16'd3;
    ena = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      checks++;
      if (step !== ((c % 4) == 0)) begin
        errors++;
        $display("FAIL step_period edge%0d: step=%b want %b", c, step, (c % 4) == 0);
      end
    end
    do_reset();
    prescale = 16'd100;
    ena = 1'b1;
    repeat (50) next_cycle();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL step_pre_shrink: step=%b want 0", step);
    end
    prescale = 16'd2;
    next_cycle();
    checks++;
    if (step !== 1'b1) begin
      errors++;
      $display("FAIL step_shrink: step=%b want 1", step);
    end
    next_cycle();
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL step_after_shrink: step=%b want 0", step);
    end
  endtask

  task automatic test_sweep();
    int exp_d[12] = '{0, 0, 4, 8, 12, 15, 15, 15, 11, 7, 3, 0};
    int exp_p[12] = '{0, 1, 1, 1, 1, 2, 2, 3, 3, 3, 3, 0};
    do_reset();
    sweep_config();
    ena = 1'b1;
    next_cycle();
    checks++;
    if (step !== 1'b1 || duty !== 4'd0) begin
      errors++;
      $display("FAIL sweep_start: step=%b duty=%0d want 1/0", step, duty);
    end
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      checks++;
      if (duty !== 4'(exp_d[k]) || phase !== 2'(exp_p[k]) || cycle_done !== (k == 11)) begin
        errors++;
        $display("FAIL sweep tick%0d: duty=%0d phase=%0d cd=%b want %0d/%0d/%b",
                 k + 1, duty, phase, cycle_done, exp_d[k], exp_p[k], k == 11);
      end
    end
    next_cycle();
    checks++;
    if (cycle_done !== 1'b0 || duty !== 4'd0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL sweep_pulse_end: cd=%b duty=%0d phase=%0d want 0/0/0",
               cycle_done, duty, phase);
    end
  endtask

  task automatic test_ena_pause();
    bit found = 0;
    do_reset();
    sweep_config();
    ena = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      next_cycle();
      if (duty == 4'd8 && phase == 2'd1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL pause_reach: duty=%0d phase=%0d want 8/1 within 20 cycles", duty, phase);
    end
    ena = 1'b0;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      checks++;
      if (step !== 1'b0 || duty !== 4'd8 || phase !== 2'd1 || cycle_done !== 1'b0) begin
        errors++;
        $display("FAIL pause cyc%0d: step=%b duty=%0d phase=%0d want 0/8/1", c, step, duty, phase);
      end
    end
    ena = 1'b1;
    next_cycle();
    checks++;
    if (step !== 1'b1 || duty !== 4'd8) begin
      errors++;
      $display("FAIL resume_step: step=%b duty=%0d want 1/8", step, duty);
    end
    next_cycle();
    checks++;
    if (duty !== 4'd12 || phase !== 2'd1) begin
      errors++;
      $display("FAIL resume_tick: duty=%0d phase=%0d want 12/1", duty, phase);
    end
  endtask

  task automatic test_reset_mid_fall();
    bit found = 0;
    do_reset();
    sweep_config();
    ena = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      next_cycle();
      if (duty == 4'd11 && phase == 2'd3) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fall_reach: duty=%0d phase=%0d want 11/3 within 30 cycles", duty, phase);
    end
    rst = 1'b0;
    next_cycle();
    checks++;
    if (duty !== 4'd0 || phase !== 2'd0 || step !== 1'b0 || cycle_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fall: duty=%0d phase=%0d step=%b cd=%b want all 0",
               duty, phase, step, cycle_done);
    end
    rst = 1'b1;
  endtask

  task automatic test_delta_edges();
    do_reset();
    prescale = 16'd0; ramp_steps = 8'd0; hold = 8'd0; delta = 4'd0;
    ena = 1'b1;
    next_cycle();
    next_cycle();
    checks++;
    if (duty !== 4'd0 || phase !== 2'd1) begin
      errors++;
      $display("FAIL delta0_enter_rise: duty=%0d phase=%0d want 0/1", duty, phase);
    end
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      checks++;
      if (duty !== 4'(k) || phase !== ((k < 15) ? 2'd1 : 2'd2)) begin
        errors++;
        $display("FAIL delta0 tick%0d: duty=%0d phase=%0d want %0d/%0d",
                 k, duty, phase, k, (k < 15) ? 1 : 2);
      end
    end
    do_reset();
    delta = 4'd15;
    ena = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    checks++;
    if (duty !== 4'd15 || phase !== 2'd2) begin
      errors++;
      $display("FAIL delta15_jump: duty=%0d phase=%0d want 15/2", duty, phase);
    end
  endtask

  task automatic test_random();
    do_reset();
    prescale = 16'd1; ramp_steps = 8'd1; delta = 4'd3; hold = 8'd1;
    ena = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      next_cycle();
      checks++;
      if (step !== m_step || duty !== 4'(m_level) || phase !== 2'(m_ph) || cycle_done !== m_cd) begin
        errors++;
        $display("FAIL random cyc%0d: step=%b duty=%0d phase=%0d cd=%b want %b/%0d/%0d/%b",
                 c, step, duty, phase, cycle_done, m_step, m_level, m_ph, m_cd);
      end
      rst = ($urandom_range(0, 299) != 0);
      ena = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) prescale   = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) ramp_steps = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) delta      = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) hold       = 8'($urandom_range(0, 3));
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_step_timing();
    test_sweep();
    test_ena_pause();
    test_reset_mid_fall();
    test_delta_edges();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
